// File: rtl/cgra_lsu_arbiter.sv
// Load/store arbiter between the CGRA tile array and one OBI-style memory port.
// Tiles are served one transaction at a time in round-robin order. Each transaction
// completes with a one-cycle Grant pulse, and loads also get a Valid pulse with the data.
module cgra_lsu_arbiter #(
  parameter int NB_TILES = 16,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NB_TILES-1:0]          Tile_Req_I,
  input  logic [NB_TILES-1:0]          Tile_Load_I,
  input  logic [NB_TILES*AWIDTH-1:0]   Tile_Addr_I,
  input  logic [NB_TILES*DWIDTH-1:0]   Tile_Wdata_I,
  output logic [NB_TILES-1:0]          Tile_Grant_O,
  output logic [NB_TILES-1:0]          Tile_Valid_O,
  output logic [DWIDTH-1:0]            Tile_Rdata_O,
  output logic                         Mem_Req_O,
  input  logic                         Mem_Gnt_I,
  output logic [AWIDTH-1:0]            Mem_Addr_O,
  output logic                         Mem_We_O,
  output logic [3:0]                   Mem_Be_O,
  output logic [DWIDTH-1:0]            Mem_Wdata_O,
  input  logic                         Mem_Rvalid_I,
  input  logic [DWIDTH-1:0]            Mem_Rdata_I,
  output logic                         Busy_O,
  output logic                         Misalign_O
);

  // state     | meaning
  // IDLE      | arbitrate among requesting tiles, latch the winner's access
  // ADDR      | memory request held until Mem_Gnt_I
  // RESP_WAIT | waiting for Mem_Rvalid_I (loads and stores alike)
  // DONE      | Grant (and Valid for loads) pulse, advance round-robin pointer

  localparam int IDXW = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, RESP_WAIT, DONE} state_t;

  state_t              state_q;
  logic [IDXW-1:0]     rr_ptr_q;
  logic [IDXW-1:0]     idx_q;
  logic                load_q;
  logic                we_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic                mem_req_q;
  logic [NB_TILES-1:0] grant_q;
  logic [NB_TILES-1:0] valid_q;
  logic [DWIDTH-1:0]   rdata_q;
  logic                misalign_q;

  logic [AWIDTH-1:0]   tile_addr  [NB_TILES];
  logic [DWIDTH-1:0]   tile_wdata [NB_TILES];
  logic                win_found;
  logic [IDXW-1:0]     win_idx;
  int                  cand;

  // Unpack the flat per-tile buses so the winner can be selected by index.
  for (genvar g = 0; g < NB_TILES; g++) begin : g_unpack
    assign tile_addr[g]  = Tile_Addr_I[g*AWIDTH +: AWIDTH];
    assign tile_wdata[g] = Tile_Wdata_I[g*DWIDTH +: DWIDTH];
  end

  // Round-robin search: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NB_TILES; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NB_TILES) cand = cand - NB_TILES;
      if (!win_found && Tile_Req_I[cand]) begin
        win_found = 1'b1;
        win_idx   = IDXW'(cand);
      end
    end
  end

  // Transaction sequencer; every outward-facing signal is registered here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      load_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_req_q  <= 1'b0;
      grant_q    <= '0;
      valid_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      grant_q <= '0;
      valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            idx_q     <= win_idx;
            load_q    <= Tile_Load_I[win_idx];
            we_q      <= ~Tile_Load_I[win_idx];
            addr_q    <= tile_addr[win_idx];
            wdata_q   <= tile_wdata[win_idx];
            mem_req_q <= 1'b1;
            // Registered on entry so the flag is already up during the ADDR cycle.
            if (tile_addr[win_idx][1:0] != 2'b00) misalign_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          // A response arriving here is a protocol violation and is ignored.
          if (Mem_Gnt_I) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP_WAIT;
          end
        end
        RESP_WAIT: begin
          if (Mem_Rvalid_I) begin
            if (load_q) rdata_q <= Mem_Rdata_I;
            grant_q[idx_q] <= 1'b1;
            valid_q[idx_q] <= load_q;
            state_q        <= DONE;
          end
        end
        DONE: begin
          rr_ptr_q <= (idx_q == IDXW'(NB_TILES - 1)) ? '0 : idx_q + IDXW'(1);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Tile_Grant_O = grant_q;
  assign Tile_Valid_O = valid_q;
  assign Tile_Rdata_O = rdata_q;
  assign Mem_Req_O    = mem_req_q;
  assign Mem_Addr_O   = {addr_q[AWIDTH-1:2], 2'b00};
  assign Mem_We_O     = we_q;
  // Full-word accesses only; enables are shown whenever a request is on the port.
  assign Mem_Be_O     = mem_req_q ? 4'hF : 4'h0;
  assign Mem_Wdata_O  = wdata_q;
  assign Busy_O       = (state_q != IDLE);
  assign Misalign_O   = misalign_q;

endmodule

// File: tb/tb_cgra_lsu_arbiter.sv
// Directed bench for cgra_lsu_arbiter: a table of single-tile transactions plus
// hand sequences for reset-in-flight and round-robin contention.
module tb_cgra_lsu_arbiter;

  localparam int NB = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [NB-1:0]     Tile_Req_I;
  logic [NB-1:0]     Tile_Load_I;
  logic [NB*AW-1:0]  Tile_Addr_I;
  logic [NB*DW-1:0]  Tile_Wdata_I;
  logic [NB-1:0]     Tile_Grant_O;
  logic [NB-1:0]     Tile_Valid_O;
  logic [DW-1:0]     Tile_Rdata_O;
  logic              Mem_Req_O;
  logic              Mem_Gnt_I;
  logic [AW-1:0]     Mem_Addr_O;
  logic              Mem_We_O;
  logic [3:0]        Mem_Be_O;
  logic [DW-1:0]     Mem_Wdata_O;
  logic              Mem_Rvalid_I;
  logic [DW-1:0]     Mem_Rdata_I;
  logic              Busy_O;
  logic              Misalign_O;

  cgra_lsu_arbiter #(.NB_TILES(NB), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .Tile_Req_I(Tile_Req_I), .Tile_Load_I(Tile_Load_I),
    .Tile_Addr_I(Tile_Addr_I), .Tile_Wdata_I(Tile_Wdata_I),
    .Tile_Grant_O(Tile_Grant_O), .Tile_Valid_O(Tile_Valid_O), .Tile_Rdata_O(Tile_Rdata_O),
    .Mem_Req_O(Mem_Req_O), .Mem_Gnt_I(Mem_Gnt_I), .Mem_Addr_O(Mem_Addr_O),
    .Mem_We_O(Mem_We_O), .Mem_Be_O(Mem_Be_O), .Mem_Wdata_O(Mem_Wdata_O),
    .Mem_Rvalid_I(Mem_Rvalid_I), .Mem_Rdata_I(Mem_Rdata_I),
    .Busy_O(Busy_O), .Misalign_O(Misalign_O)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_tile(input int t, input bit ld, input logic [31:0] a, input logic [31:0] w);
    Tile_Load_I[t]          = ld;
    Tile_Addr_I[t*AW +: AW] = a;
    Tile_Wdata_I[t*DW +: DW] = w;
  endtask

  task automatic wait_mem_req(output bit got);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (Mem_Req_O) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_grant"}, Tile_Grant_O, 0);
    chk({name, "_valid"}, Tile_Valid_O, 0);
    chk({name, "_req"},   Mem_Req_O, 0);
    chk({name, "_busy"},  Busy_O, 0);
  endtask

  // One memory transaction for an already-requesting tile; checks arbitration order.
  task automatic serve(input int exp_t);
    bit got;
    wait_mem_req(got);
    chk("rr_mem_req", got, 1);
    chk("rr_addr", Mem_Addr_O, 32'h1000 + exp_t * 16);
    Mem_Gnt_I = 1'b1;
    @(negedge Clk);
    Mem_Gnt_I    = 1'b0;
    Mem_Rvalid_I = 1'b1;
    Mem_Rdata_I  = 32'hA0A0_0000 + exp_t;
    @(negedge Clk);
    Mem_Rvalid_I = 1'b0;
    chk("rr_grant", Tile_Grant_O, 64'd1 << exp_t);
    Tile_Req_I[exp_t] = 1'b0;
  endtask

  typedef struct {
    int          tile;
    bit          load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    bit          rv_in_addr;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    bit          exp_mis;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit got;
    int lat;

    vecs[0] = '{tile:3,  load:1, addr:32'h100,  wdata:32'h0,        rdata:32'hDEADBEEF,
                gnt_dly:0, rv_dly:0, rv_in_addr:0, exp_addr:32'h100,  exp_rdata:32'hDEADBEEF, exp_mis:0};
    vecs[1] = '{tile:0,  load:0, addr:32'h40,   wdata:32'h12345678, rdata:32'hAAAA5555,
                gnt_dly:0, rv_dly:0, rv_in_addr:0, exp_addr:32'h40,   exp_rdata:32'hDEADBEEF, exp_mis:0};
    vecs[2] = '{tile:7,  load:1, addr:32'h2000, wdata:32'h77777777, rdata:32'h0BADF00D,
                gnt_dly:5, rv_dly:0, rv_in_addr:1, exp_addr:32'h2000, exp_rdata:32'h0BADF00D, exp_mis:0};
    vecs[3] = '{tile:15, load:0, addr:32'h3FFC, wdata:32'hCAFEF00D, rdata:32'h99999999,
                gnt_dly:2, rv_dly:3, rv_in_addr:0, exp_addr:32'h3FFC, exp_rdata:32'h0BADF00D, exp_mis:0};
    vecs[4] = '{tile:9,  load:1, addr:32'h103,  wdata:32'h0,        rdata:32'h55AA55AA,
                gnt_dly:0, rv_dly:0, rv_in_addr:0, exp_addr:32'h100,  exp_rdata:32'h55AA55AA, exp_mis:1};
    vecs[5] = '{tile:2,  load:0, addr:32'h204,  wdata:32'h0F0F0F0F, rdata:32'h0,
                gnt_dly:1, rv_dly:1, rv_in_addr:0, exp_addr:32'h204,  exp_rdata:32'h55AA55AA, exp_mis:1};

    Reset        = 1'b0;
    Tile_Req_I   = '0;
    Tile_Load_I  = '0;
    Tile_Addr_I  = '0;
    Tile_Wdata_I = '0;
    Mem_Gnt_I    = 1'b0;
    Mem_Rvalid_I = 1'b0;
    Mem_Rdata_I  = '0;
    repeat (3) @(negedge Clk);

    chk_quiet("reset");
    chk("reset_rdata", Tile_Rdata_O, 0);
    chk("reset_addr",  Mem_Addr_O, 0);
    chk("reset_we",    Mem_We_O, 0);
    chk("reset_be",    Mem_Be_O, 0);
    chk("reset_wdata", Mem_Wdata_O, 0);
    chk("reset_mis",   Misalign_O, 0);
    Reset = 1'b1;

    // Table-driven single-tile transactions.
    foreach (vecs[i]) begin
      @(negedge Clk);
      set_tile(vecs[i].tile, vecs[i].load, vecs[i].addr, vecs[i].wdata);
      Tile_Req_I[vecs[i].tile] = 1'b1;
      lat = 0;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge Clk);
        lat++;
        if (Mem_Req_O) begin
          got = 1'b1;
          break;
        end
      end
      chk("mem_req_seen", got, 1);
      chk("mem_addr",  Mem_Addr_O, vecs[i].exp_addr);
      chk("mem_we",    Mem_We_O, !vecs[i].load);
      chk("mem_wdata", Mem_Wdata_O, vecs[i].wdata);
      chk("mem_be",    Mem_Be_O, 4'hF);
      chk("busy_addr", Busy_O, 1);
      Mem_Rvalid_I = vecs[i].rv_in_addr;
      Mem_Rdata_I  = 32'h11111111;
      for (int c = 0; c < vecs[i].gnt_dly; c++) begin
        @(negedge Clk);
        lat++;
        chk("req_hold",  Mem_Req_O, 1);
        chk("addr_hold", Mem_Addr_O, vecs[i].exp_addr);
        chk("no_early_grant", Tile_Grant_O, 0);
      end
      Mem_Rvalid_I = 1'b0;
      Mem_Gnt_I    = 1'b1;
      @(negedge Clk);
      lat++;
      Mem_Gnt_I = 1'b0;
      chk("req_drop", Mem_Req_O, 0);
      chk("busy_resp", Busy_O, 1);
      for (int c = 0; c < vecs[i].rv_dly; c++) begin
        @(negedge Clk);
        lat++;
        chk("resp_wait_req",   Mem_Req_O, 0);
        chk("resp_wait_grant", Tile_Grant_O, 0);
      end
      Mem_Rvalid_I = 1'b1;
      Mem_Rdata_I  = vecs[i].rdata;
      @(negedge Clk);
      lat++;
      Mem_Rvalid_I = 1'b0;
      chk("grant",   Tile_Grant_O, 64'd1 << vecs[i].tile);
      chk("valid",   Tile_Valid_O, vecs[i].load ? (64'd1 << vecs[i].tile) : 64'd0);
      chk("rdata",   Tile_Rdata_O, vecs[i].exp_rdata);
      chk("latency", lat, 3 + vecs[i].gnt_dly + vecs[i].rv_dly);
      chk("misalign", Misalign_O, vecs[i].exp_mis);
      Tile_Req_I[vecs[i].tile] = 1'b0;
      @(negedge Clk);
      chk_quiet("after_done");
      chk("rdata_hold", Tile_Rdata_O, vecs[i].exp_rdata);
    end

    // Reset while waiting for the memory response; the late response must be dropped.
    @(negedge Clk);
    set_tile(4, 1'b1, 32'h80, 32'h0);
    Tile_Req_I[4] = 1'b1;
    wait_mem_req(got);
    chk("rst_mem_req", got, 1);
    Mem_Gnt_I = 1'b1;
    @(negedge Clk);
    Mem_Gnt_I = 1'b0;
    chk("rst_busy_before", Busy_O, 1);
    Reset         = 1'b0;
    Tile_Req_I[4] = 1'b0;
    #1;
    chk_quiet("rst_async");
    chk("rst_rdata", Tile_Rdata_O, 0);
    chk("rst_mis",   Misalign_O, 0);
    chk("rst_addr",  Mem_Addr_O, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Mem_Rvalid_I = 1'b1;
    Mem_Rdata_I  = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      Mem_Rvalid_I = 1'b0;
      chk_quiet("late_rvalid");
      chk("late_rdata", Tile_Rdata_O, 0);
    end

    // Round-robin contention starting from rr_ptr = 0 after the reset above.
    for (int t = 0; t < NB; t++) set_tile(t, 1'b1, 32'h1000 + t * 16, t);
    @(negedge Clk);
    Tile_Req_I = 16'h8022;
    serve(1);
    serve(5);
    serve(15);
    repeat (3) begin
      @(negedge Clk);
      chk_quiet("rr_idle1");
    end
    Tile_Req_I = '1;
    for (int t = 0; t < NB; t++) serve(t);
    repeat (3) begin
      @(negedge Clk);
      chk_quiet("rr_idle2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
